// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access unit: op codes, exception codes,
// controller states and op classification helpers.
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd3,
      LHU = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      EXC_NONE = 2'b00,
      EXC_ADEL = 2'b01,
      EXC_ADES = 2'b10,
      EXC_BUS  = 2'b11
   } exc_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic is_store(input op_e op);
      return op inside {SB, SH, SW};
   endfunction

   function automatic logic is_half(input op_e op);
      return op inside {LH, LHU, SH};
   endfunction

   function automatic logic is_word(input op_e op);
      return op inside {LW, SW};
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// way out, lane select plus sign/zero extension on the way back.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  op_e                op,
   input  logic [1:0]         addr_lo,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [DATA_W-1:0]  rdata,
   output logic [3:0]         we,
   output logic [DATA_W-1:0]  wdata_rep,
   output logic [DATA_W-1:0]  rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      we        = 4'b0000;
      wdata_rep = wdata;
      case (op)
         SB: begin
            we        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         SH: begin
            we        = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
         end
         SW:      we = 4'b1111;
         default: we = 4'b0000;
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Stores return zero so the response word is clean for the pipeline.
   always_comb begin
      case (op)
         LB:      rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         LBU:     rdata_ext = {24'd0, byte_sel};
         LH:      rdata_ext = {{16{half_sel[15]}}, half_sel};
         LHU:     rdata_ext = {16'd0, half_sel};
         LW:      rdata_ext = rdata;
         default: rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store controller: alignment/range check, RAM req/ack with
// timeout, and a one-cycle registered response with load data or exception.
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter logic [ADDR_W-1:0] MEM_BYTES = 32'h0001_0000,
   parameter int unsigned       TIMEOUT   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               resp_valid,
   output logic [DATA_W-1:0]  resp_rdata,
   output logic [1:0]         resp_exc,
   output logic               busy,
   output logic               mem_en,
   output logic [3:0]         mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ack
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e             state, state_nxt;
   op_e                req_op_e;
   op_e                op_q;
   logic [1:0]         addr_lo_q;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  rdata_q;
   exc_e               exc_q;

   logic               fault;
   logic               accept;
   logic               take_ack;
   logic               expire;

   op_e                lane_op;
   logic [1:0]         lane_addr_lo;
   logic [3:0]         lane_we;
   logic [DATA_W-1:0]  lane_wdata;
   logic [DATA_W-1:0]  lane_rdata;

   assign req_op_e = op_e'(req_op);

   assign fault = (is_half(req_op_e) && req_addr[0])
               || (is_word(req_op_e) && (req_addr[1:0] != 2'b00))
               || (req_addr >= MEM_BYTES);

   // In IDLE the aligner steers the incoming store; afterwards it decodes the
   // returning word using the op and lane captured at accept.
   assign lane_op      = (state == ST_IDLE) ? req_op_e : op_q;
   assign lane_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

   dmem_lane_align u_lane_align (
      .op        (lane_op),
      .addr_lo   (lane_addr_lo),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .we        (lane_we),
      .wdata_rep (lane_wdata),
      .rdata_ext (lane_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = fault ? ST_RESP : ST_WAIT;
         ST_WAIT: if (take_ack || expire) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The counter tops out at TIMEOUT-1: that cycle is the TIMEOUT-th without
   // an ack, and an ack arriving in it still takes priority.
   always_comb begin
      req_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE) || req_valid;
      accept    = (state == ST_IDLE) && req_valid;
      take_ack  = (state == ST_WAIT) && mem_en && mem_ack;
      expire    = (state == ST_WAIT) && !take_ack && (cnt == CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= LB;
         addr_lo_q  <= 2'b00;
         cnt        <= '0;
         rdata_q    <= '0;
         exc_q      <= EXC_NONE;
         mem_en     <= 1'b0;
         mem_we     <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_exc   <= EXC_NONE;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            op_q      <= req_op_e;
            addr_lo_q <= req_addr[1:0];
            cnt       <= '0;
            rdata_q   <= '0;
            if (fault) begin
               exc_q <= is_store(req_op_e) ? EXC_ADES : EXC_ADEL;
            end else begin
               exc_q     <= EXC_NONE;
               mem_en    <= 1'b1;
               mem_we    <= lane_we;
               mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
               mem_wdata <= lane_wdata;
            end
         end
         if (take_ack) begin
            rdata_q <= lane_rdata;
            mem_en  <= 1'b0;
            mem_we  <= 4'b0000;
            cnt     <= '0;
         end else if (expire) begin
            exc_q  <= EXC_BUS;
            mem_en <= 1'b0;
            mem_we <= 4'b0000;
            cnt    <= '0;
         end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (state == ST_RESP) begin
            resp_valid <= 1'b1;
            resp_rdata <= rdata_q;
            resp_exc   <= exc_q;
         end
      end
   end

endmodule
